// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the board reset sequencer: state encoding and
// default timing constants used by board top-levels.
package reset_seq_defs;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NDOM    = 3;
  localparam int DEF_HOLD    = 16;
  localparam int DEF_GAP     = 8;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Two-flop synchroniser with asynchronous active-low clear; output is 0
// while cleared and follows d_i two edges later.
module sync_bit (
  input  logic clock,
  input  logic arstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clock or negedge arstn) begin
    if (!arstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: holds all domains in reset until PLL lock is stable,
// then releases per-domain resets in index order, gated by each domain's ack.
module reset_sequencer
  import reset_seq_defs::*;
#(
  parameter int NDOM    = DEF_NDOM,
  parameter int HOLD    = DEF_HOLD,
  parameter int GAP     = DEF_GAP,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clock,
  input  logic            arstn,
  input  logic            pll_lock,
  input  logic            soft_req,
  input  logic [NDOM-1:0] ack,
  output logic [NDOM-1:0] rstn_out,
  output logic            busy,
  output logic            done,
  output logic [NDOM-1:0] ack_err
);

  localparam int CNTW = $clog2(((HOLD > TIMEOUT) ? HOLD : TIMEOUT) + 1);
  localparam int IDXW = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP - 1);
  localparam logic [CNTW-1:0] TO_LAST   = CNTW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NDOM - 1);

  seq_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [IDXW-1:0] idx_q, idx_d, idx_nxt_s;
  logic [NDOM-1:0] rstn_q, rstn_d;
  logic [NDOM-1:0] err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            lock_s;
  logic [NDOM-1:0] ack_s;
  logic            abort_s;
  logic            adv_s;

  sync_bit u_sync_lock (
    .clock (clock),
    .arstn (arstn),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  for (genvar g = 0; g < NDOM; g++) begin : g_ack_sync
    sync_bit u_sync_ack (
      .clock (clock),
      .arstn (arstn),
      .d_i   (ack[g]),
      .q_o   (ack_s[g])
    );
  end

  assign abort_s   = soft_req | ~lock_s;
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);
  assign idx_nxt_s = idx_q + IDXW'(1);

  // Next-state, counter, stage index and reset-vector decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    err_d   = err_q;
    adv_s   = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        rstn_d = '0;
        idx_d  = '0;
        if (abort_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          rstn_d[0] = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RELEASE: begin
        if (abort_s) begin
          state_d = ST_ASSERT;
          rstn_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
          if (ack_s[idx_q] && (cnt_q >= GAP_LAST)) begin
            adv_s = 1'b1;
          end else if (!ack_s[idx_q] && (cnt_q == TO_LAST)) begin
            adv_s         = 1'b1;
            err_d[idx_q]  = 1'b1;
          end else begin
            adv_s = 1'b0;
          end
          // Last stage leaves for RUN; otherwise release the next domain
          if (adv_s && (idx_q == LAST_IDX)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (adv_s) begin
            idx_d             = idx_nxt_s;
            rstn_d[idx_nxt_s] = 1'b1;
            cnt_d             = '0;
          end else begin
            idx_d = idx_q;
          end
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_d = ST_ASSERT;
          rstn_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          rstn_d = '1;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        rstn_d  = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_RUN);
    done_d = (state_d == ST_RUN);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clock or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rstn_out = rstn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = err_q;

endmodule
